// File: rtl/jt12_eg_state.sv
// Envelope state store and key-event sequencer for the 24 FM operator slots.
// It walks one slot per clk_en and holds the loop-back envelope state, the SSG flag and the key history.
module jt12_eg_state (
    input  logic       rst,
    input  logic       clk,
    input  logic       clk_en,
    input  logic       kon_we,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_op,
    input  logic [2:0] state_next,
    input  logic       ssg_inv_next,
    output logic [4:0] slot,
    output logic       zero,
    output logic [2:0] state_in,
    output logic       ssg_inv_in,
    output logic       keyon_now,
    output logic       keyoff_now
);

    logic [4:0]  slot_q, slot_d;
    logic [23:0] kon_req_q, kon_req_d;
    logic [23:0] key_prev_q;
    logic [23:0] inv_mem_q;
    logic [2:0]  st_mem_q [24];

    logic [2:0]  ch_idx;
    logic        ch_valid;

    // Channel codes 4..6 address the second group of three channels; low bits 11 are unused codes.
    always_comb begin
        ch_valid = (kon_ch[1:0] != 2'd3);
        ch_idx   = kon_ch[2] ? ({1'b0, kon_ch[1:0]} + 3'd3) : {1'b0, kon_ch[1:0]};
    end

    always_comb begin
        kon_req_d = kon_req_q;
        if (kon_we && ch_valid) begin
            for (int k = 0; k < 4; k++) begin
                kon_req_d[5'(k * 6) + {2'b00, ch_idx}] = kon_op[k];
            end
        end
    end

    always_comb begin
        slot_d = (slot_q == 5'd23) ? 5'd0 : slot_q + 5'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kon_req_q <= '0;
        end else begin
            kon_req_q <= kon_req_d;
        end
    end

    // key_prev samples the pre-edge request, so a write on the retiring edge waits a full rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            key_prev_q <= '0;
            inv_mem_q  <= '0;
            for (int i = 0; i < 24; i++) begin
                st_mem_q[i] <= '0;
            end
        end else if (clk_en) begin
            st_mem_q[slot_q]   <= state_next;
            inv_mem_q[slot_q]  <= ssg_inv_next;
            key_prev_q[slot_q] <= kon_req_q[slot_q];
            slot_q             <= slot_d;
        end
    end

    assign slot       = slot_q;
    assign zero       = (slot_q == 5'd0);
    assign state_in   = st_mem_q[slot_q];
    assign ssg_inv_in = inv_mem_q[slot_q];
    assign keyon_now  = kon_req_q[slot_q] & ~key_prev_q[slot_q];
    assign keyoff_now = ~kon_req_q[slot_q] & key_prev_q[slot_q];

endmodule
